// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences IF/ID/EXE/MEM/WB, decodes op/func into
// datapath enables and ALU codes, and counts retired instructions.
module mc_control_unit #(
  parameter int unsigned INST_CNT_W = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [5:0]            op,
  input  logic [5:0]            func,
  input  logic                  z,
  output logic                  pc_wen,
  output logic                  ir_wen,
  output logic                  iord,
  output logic                  mem_wen,
  output logic                  reg_wen,
  output logic                  regdst,
  output logic                  m2reg,
  output logic                  jal,
  output logic                  sext,
  output logic [1:0]            alusrca,
  output logic [1:0]            alusrcb,
  output logic [3:0]            aluc,
  output logic [1:0]            pcsrc,
  output logic [2:0]            state,
  output logic                  illegal,
  output logic [INST_CNT_W-1:0] inst_count
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_e                state_q, state_d;
  logic [INST_CNT_W-1:0] cnt_q;
  logic                  retire;

  logic is_r, r_alu, r_shift, r_jr;
  logic i_alu, i_addi, i_lw, i_sw, i_beq, i_bne, i_j, i_jal, legal;
  logic [3:0] exe_aluc;

  assign is_r    = (op == 6'b000000);
  assign r_alu   = is_r && (func inside {6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b100110});
  assign r_shift = is_r && (func inside {6'b000000, 6'b000010, 6'b000011});
  assign r_jr    = is_r && (func == 6'b001000);
  assign i_addi  = (op == 6'b001000);
  assign i_alu   = op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
  assign i_lw    = (op == 6'b100011);
  assign i_sw    = (op == 6'b101011);
  assign i_beq   = (op == 6'b000100);
  assign i_bne   = (op == 6'b000101);
  assign i_j     = (op == 6'b000010);
  assign i_jal   = (op == 6'b000011);
  assign legal   = r_alu | r_shift | r_jr | i_alu | i_lw | i_sw |
                   i_beq | i_bne | i_j | i_jal;

  always_comb begin
    exe_aluc = ALU_ADD;
    if (is_r) begin
      case (func)
        6'b100010: exe_aluc = ALU_SUB;
        6'b100100: exe_aluc = ALU_AND;
        6'b100101: exe_aluc = ALU_OR;
        6'b100110: exe_aluc = ALU_XOR;
        6'b000000: exe_aluc = ALU_SLL;
        6'b000010: exe_aluc = ALU_SRL;
        6'b000011: exe_aluc = ALU_SRA;
        default:   exe_aluc = ALU_ADD;
      endcase
    end else begin
      case (op)
        6'b001100: exe_aluc = ALU_AND;
        6'b001101: exe_aluc = ALU_OR;
        6'b001110: exe_aluc = ALU_XOR;
        6'b001111: exe_aluc = ALU_LUI;
        default:   exe_aluc = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    pc_wen  = 1'b0;
    ir_wen  = 1'b0;
    iord    = 1'b0;
    mem_wen = 1'b0;
    reg_wen = 1'b0;
    regdst  = 1'b0;
    m2reg   = 1'b0;
    jal     = 1'b0;
    sext    = 1'b0;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    aluc    = ALU_ADD;
    pcsrc   = 2'b00;
    illegal = 1'b0;
    retire  = 1'b0;
    state_d = S_IF;
    unique case (state_q)
      S_IF: begin
        ir_wen  = 1'b1;
        pc_wen  = 1'b1;
        alusrcb = 2'b01;
        state_d = S_ID;
      end
      S_ID: begin
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (!legal) begin
          illegal = 1'b1;
        end else if (i_j || i_jal) begin
          pc_wen  = 1'b1;
          pcsrc   = 2'b11;
          reg_wen = i_jal;
          jal     = i_jal;
          retire  = 1'b1;
        end else if (r_jr) begin
          pc_wen = 1'b1;
          pcsrc  = 2'b10;
          retire = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq || i_bne) begin
          alusrca = 2'b01;
          aluc    = ALU_SUB;
          pcsrc   = 2'b01;
          pc_wen  = i_beq ? z : ~z;
          retire  = 1'b1;
        end else if (r_alu || r_shift) begin
          alusrca = r_shift ? 2'b10 : 2'b01;
          aluc    = exe_aluc;
          state_d = S_WB;
        end else if (i_alu || i_lw || i_sw) begin
          alusrca = 2'b01;
          alusrcb = 2'b10;
          sext    = i_addi | i_lw | i_sw;
          aluc    = exe_aluc;
          state_d = (i_lw || i_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (i_sw) begin
          mem_wen = 1'b1;
          retire  = 1'b1;
        end else if (i_lw) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_wen = 1'b1;
        regdst  = is_r;
        m2reg   = i_lw;
        retire  = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    // Asserted reset forces every control quietly to zero, even though IF is the reset state.
    if (!resetn) begin
      {pc_wen, ir_wen, iord, mem_wen, reg_wen, regdst, m2reg, jal, sext} = '0;
      {alusrca, alusrcb, aluc, pcsrc, illegal, retire} = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + INST_CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expectations go through a
// scoreboard queue and are compared at the falling edge.
module tb_mc_control_unit;

  logic       clock, resetn, z;
  logic [5:0] op, func;
  logic       pc_wen, ir_wen, iord, mem_wen, reg_wen, regdst, m2reg, jal, sext, illegal;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;
  logic [3:0] inst_count;

  mc_control_unit #(.INST_CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
    .pc_wen(pc_wen), .ir_wen(ir_wen), .iord(iord), .mem_wen(mem_wen),
    .reg_wen(reg_wen), .regdst(regdst), .m2reg(m2reg), .jal(jal), .sext(sext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc),
    .state(state), .illegal(illegal), .inst_count(inst_count)
  );

  typedef struct packed {
    logic pc_wen, ir_wen, iord, mem_wen, reg_wen, regdst, m2reg, jal, sext;
    logic [1:0] alusrca, alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsrc;
    logic illegal;
    logic [2:0] state;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_cnt = 4'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t e_st(input logic [2:0] s);
    obs_t e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic obs_t e_if();
    obs_t e = e_st(3'd0);
    e.pc_wen = 1'b1; e.ir_wen = 1'b1; e.alusrcb = 2'b01;
    return e;
  endfunction

  function automatic obs_t e_id();
    obs_t e = e_st(3'd1);
    e.alusrcb = 2'b11; e.sext = 1'b1;
    return e;
  endfunction

  task automatic check_pop();
    exp_t x;
    obs_t o;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    x = sb.pop_front();
    o = {pc_wen, ir_wen, iord, mem_wen, reg_wen, regdst, m2reg, jal, sext,
         alusrca, alusrcb, aluc, pcsrc, illegal, state, inst_count};
    assert (o === x.v) else begin
      failures++;
      $error("FAIL %s: got %p required %p", x.tag, o, x.v);
    end
  endtask

  // Entered just after a rising edge; checks this cycle's outputs, then advances one cycle.
  task automatic cyc(input string tag, input obs_t e, input bit ret);
    e.cnt = exp_cnt;
    sb.push_back('{tag, e});
    @(negedge clock);
    check_pop();
    @(posedge clock);
    #1;
    if (ret) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic now_check(input string tag, input obs_t e);
    e.cnt = exp_cnt;
    sb.push_back('{tag, e});
    check_pop();
  endtask

  task automatic r_op(input string tag, input logic [5:0] f, input logic [3:0] a,
                      input logic [1:0] sa);
    obs_t e;
    op = 6'b000000; func = f; z = 1'b0;
    cyc({tag, "_if"}, e_if(), 1'b0);
    cyc({tag, "_id"}, e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = sa; e.aluc = a;
    cyc({tag, "_exe"}, e, 1'b0);
    e = e_st(3'd4); e.reg_wen = 1'b1; e.regdst = 1'b1;
    cyc({tag, "_wb"}, e, 1'b1);
  endtask

  task automatic i_op(input string tag, input logic [5:0] o, input logic [3:0] a,
                      input logic sx);
    obs_t e;
    op = o; func = 6'b000000; z = 1'b0;
    cyc({tag, "_if"}, e_if(), 1'b0);
    cyc({tag, "_id"}, e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = 2'b01; e.alusrcb = 2'b10; e.aluc = a; e.sext = sx;
    cyc({tag, "_exe"}, e, 1'b0);
    e = e_st(3'd4); e.reg_wen = 1'b1;
    cyc({tag, "_wb"}, e, 1'b1);
  endtask

  task automatic br(input string tag, input logic [5:0] o, input logic zz, input logic pcw);
    obs_t e;
    op = o; func = 6'b000000; z = zz;
    cyc({tag, "_if"}, e_if(), 1'b0);
    cyc({tag, "_id"}, e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = 2'b01; e.aluc = 4'b0100; e.pcsrc = 2'b01; e.pc_wen = pcw;
    cyc({tag, "_exe"}, e, 1'b1);
  endtask

  task automatic jump(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic [1:0] ps, input logic lnk);
    obs_t e;
    op = o; func = f; z = 1'b0;
    cyc({tag, "_if"}, e_if(), 1'b0);
    e = e_id(); e.pc_wen = 1'b1; e.pcsrc = ps; e.reg_wen = lnk; e.jal = lnk;
    cyc({tag, "_id"}, e, 1'b1);
  endtask

  task automatic bad(input string tag, input logic [5:0] o, input logic [5:0] f);
    obs_t e;
    op = o; func = f; z = 1'b0;
    cyc({tag, "_if"}, e_if(), 1'b0);
    e = e_id(); e.illegal = 1'b1;
    cyc({tag, "_id"}, e, 1'b0);
  endtask

  initial begin
    obs_t e;
    resetn = 1'b0; op = 6'b000000; func = 6'b100000; z = 1'b0;
    #3;
    now_check("reset_hold", e_st(3'd0));
    @(posedge clock); #1;
    resetn = 1'b1;

    r_op("add", 6'b100000, 4'b0000, 2'b01);
    r_op("sub", 6'b100010, 4'b0100, 2'b01);
    r_op("sra", 6'b000011, 4'b1111, 2'b10);
    r_op("sll", 6'b000000, 4'b0011, 2'b10);
    i_op("ori", 6'b001101, 4'b0101, 1'b0);
    i_op("addi", 6'b001000, 4'b0000, 1'b1);

    op = 6'b100011; func = 6'b000000;
    cyc("lw_if", e_if(), 1'b0);
    cyc("lw_id", e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = 2'b01; e.alusrcb = 2'b10; e.sext = 1'b1;
    cyc("lw_exe", e, 1'b0);
    e = e_st(3'd3); e.iord = 1'b1;
    cyc("lw_mem", e, 1'b0);
    e = e_st(3'd4); e.reg_wen = 1'b1; e.m2reg = 1'b1;
    cyc("lw_wb", e, 1'b1);

    op = 6'b101011;
    cyc("sw_if", e_if(), 1'b0);
    cyc("sw_id", e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = 2'b01; e.alusrcb = 2'b10; e.sext = 1'b1;
    cyc("sw_exe", e, 1'b0);
    e = e_st(3'd3); e.iord = 1'b1; e.mem_wen = 1'b1;
    cyc("sw_mem", e, 1'b1);

    br("beq_z1", 6'b000100, 1'b1, 1'b1);
    br("beq_z0", 6'b000100, 1'b0, 1'b0);
    br("bne_z1", 6'b000101, 1'b1, 1'b0);
    br("bne_z0", 6'b000101, 1'b0, 1'b1);

    jump("j",   6'b000010, 6'b000000, 2'b11, 1'b0);
    jump("jr",  6'b000000, 6'b001000, 2'b10, 1'b0);
    jump("jal", 6'b000011, 6'b000000, 2'b11, 1'b1);

    bad("ill_op", 6'b111111, 6'b000000);
    bad("ill_func", 6'b000000, 6'b000001);
    r_op("add_after_ill", 6'b100000, 4'b0000, 2'b01);

    op = 6'b000000; func = 6'b100000;
    cyc("rst_add_if", e_if(), 1'b0);
    cyc("rst_add_id", e_id(), 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    exp_cnt = 4'd0;
    now_check("reset_async", e_st(3'd0));
    @(negedge clock);
    now_check("reset_held_edge", e_st(3'd0));
    @(posedge clock); #1;
    resetn = 1'b1;
    cyc("post_reset_if", e_if(), 1'b0);
    cyc("post_reset_id", e_id(), 1'b0);
    e = e_st(3'd2); e.alusrca = 2'b01;
    cyc("post_reset_exe", e, 1'b0);
    e = e_st(3'd4); e.reg_wen = 1'b1; e.regdst = 1'b1;
    cyc("post_reset_wb", e, 1'b1);

    for (int i = 0; i < 15; i++) r_op("wrap_add", 6'b100000, 4'b0000, 2'b01);
    cyc("wrap_to_zero", e_if(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
